// File: rtl/rom_stream_reader.sv
// rom_stream_reader
//
// Burst read sequencer for a ROM with a 1-cycle synchronous read. On start it
// reads len_i consecutive words beginning at base_addr_i. The address wraps from
// WORD_COUNT-1 to 0. The words are delivered as a valid/ready stream through a
// 2-entry registered buffer, so backpressure never drops a word.
//
// Ports
//   clk_i        clock, rising edge
//   rstn_i       asynchronous active-low reset
//   start_i      start a burst (sampled only while idle)
//   base_addr_i  first word address, sampled with start_i
//   len_i        number of words, sampled with start_i (0 = empty burst)
//   busy_o       burst in progress
//   done_o       one-cycle pulse when the burst has finished
//   rom_addr_o   address to the ROM
//   rom_data_i   data from the ROM, one cycle after the address
//   m_data_o     stream data
//   m_valid_o    stream valid
//   m_last_o     final word of the burst
//   m_ready_i    stream ready
module rom_stream_reader #(
   parameter int WORD_WIDTH = 8,
   parameter int WORD_COUNT = 256,
   localparam int ADDR_WIDTH = $clog2(WORD_COUNT),
   localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [WORD_WIDTH-1:0] rom_data_i,
   output logic [WORD_WIDTH-1:0] m_data_o,
   output logic                  m_valid_o,
   output logic                  m_last_o,
   input  logic                  m_ready_i
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(WORD_COUNT - 1);

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic                  inflight_q, inflight_d;
   logic                  inflight_last_q, inflight_last_d;
   logic [WORD_WIDTH-1:0] buf_data_q [2];
   logic [WORD_WIDTH-1:0] buf_data_d [2];
   logic [1:0]            buf_last_q, buf_last_d;
   logic [1:0]            count_q, count_d;

   logic                  pop;
   logic                  issue;
   logic [2:0]            occupancy;
   logic                  wr_slot;

   // Issue is throttled so that everything already buffered plus the word in
   // flight, minus what leaves this cycle, still leaves room for the new word.
   always_comb begin
      pop       = (count_q != 2'd0) && m_ready_i;
      occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);
      issue     = (state_q == ST_RUN) && (rem_q != '0) && (occupancy < 3'd2);
   end

   // Sequencing: address counter, remaining count and state. An empty burst
   // still spends one cycle in RUN so that busy_o is visible for it; RUN exits
   // on the edge where the final buffered word leaves.
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      rem_d           = rem_q;
      inflight_d      = issue;
      inflight_last_d = issue && (rem_q == LEN_WIDTH'(1));
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               addr_d  = base_addr_i;
               rem_d   = len_i;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (issue) begin
               addr_d = (addr_q == ADDR_MAX) ? '0 : addr_q + ADDR_WIDTH'(1);
               rem_d  = rem_q - LEN_WIDTH'(1);
            end
            if ((rem_q == '0) && !inflight_q &&
                ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output buffer as a 2-deep shift queue: head in slot 0. A word returning
   // from the ROM lands in the first free slot after this cycle's pop.
   always_comb begin
      buf_data_d = buf_data_q;
      buf_last_d = buf_last_q;
      wr_slot    = 1'b0;
      if (pop) begin
         buf_data_d[0] = buf_data_q[1];
         buf_last_d[0] = buf_last_q[1];
      end
      if (inflight_q) begin
         wr_slot = ((count_q - 2'(pop)) != 2'd0);
         if (wr_slot) begin
            buf_data_d[1] = rom_data_i;
            buf_last_d[1] = inflight_last_q;
         end else begin
            buf_data_d[0] = rom_data_i;
            buf_last_d[0] = inflight_last_q;
         end
      end
      count_d = count_q - 2'(pop) + 2'(inflight_q);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q         <= ST_IDLE;
         addr_q          <= '0;
         rem_q           <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         buf_data_q[0]   <= '0;
         buf_data_q[1]   <= '0;
         buf_last_q      <= '0;
         count_q         <= '0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         rem_q           <= rem_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         buf_data_q      <= buf_data_d;
         buf_last_q      <= buf_last_d;
         count_q         <= count_d;
      end
   end

   assign busy_o     = (state_q == ST_RUN);
   assign done_o     = (state_q == ST_DONE);
   assign rom_addr_o = addr_q;
   assign m_valid_o  = (count_q != 2'd0);
   assign m_data_o   = buf_data_q[0];
   assign m_last_o   = buf_last_q[0] && m_valid_o;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Testbench for rom_stream_reader. Instance A uses the default 256-word ROM,
// instance B a 200-word ROM to exercise non power-of-two wrap. Both ROMs hold
// ROM[i] = i, so each streamed word equals the address it was read from.
module tb_rom_stream_reader;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic       clk;
   logic       rstn;

   logic       start_a;
   logic [7:0] base_a;
   logic [8:0] len_a;
   logic       busy_a, done_a;
   logic [7:0] rom_addr_a, rom_data_a, m_data_a;
   logic       m_valid_a, m_last_a;
   logic       m_ready_a = 1'b1;

   logic       start_b;
   logic [7:0] base_b;
   logic [8:0] len_b;
   logic       busy_b, done_b;
   logic [7:0] rom_addr_b, rom_data_b, m_data_b;
   logic       m_valid_b, m_last_b;
   logic       m_ready_b;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   rand_ready = 0;

   exp_t sb_a[$];
   exp_t sb_b[$];

   int   start_edge;
   int   first_valid_cyc, last_xfer_cyc, done_cyc;
   int   valid_cycles, busy_cycles, done_count;
   bit   prev_stall;
   logic [7:0] prev_data;
   logic prev_last;

   int   first_valid_b, last_xfer_b, done_count_b;

   rom_stream_reader #(.WORD_WIDTH(8), .WORD_COUNT(256)) dut_a (
      .clk_i(clk), .rstn_i(rstn), .start_i(start_a), .base_addr_i(base_a),
      .len_i(len_a), .busy_o(busy_a), .done_o(done_a), .rom_addr_o(rom_addr_a),
      .rom_data_i(rom_data_a), .m_data_o(m_data_a), .m_valid_o(m_valid_a),
      .m_last_o(m_last_a), .m_ready_i(m_ready_a)
   );

   rom_stream_reader #(.WORD_WIDTH(8), .WORD_COUNT(200)) dut_b (
      .clk_i(clk), .rstn_i(rstn), .start_i(start_b), .base_addr_i(base_b),
      .len_i(len_b), .busy_o(busy_b), .done_o(done_b), .rom_addr_o(rom_addr_b),
      .rom_data_i(rom_data_b), .m_data_o(m_data_b), .m_valid_o(m_valid_b),
      .m_last_o(m_last_b), .m_ready_i(m_ready_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Identity ROMs with one-cycle synchronous read.
   always @(posedge clk) begin
      rom_data_a <= rom_addr_a;
      rom_data_b <= rom_addr_b;
   end

   // Ready for instance A: held high, or a coin flip each cycle when enabled.
   always @(posedge clk) begin
      #1;
      m_ready_a = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Monitor for instance A: scoreboard compare on every transfer, stall
   // stability, and per-burst statistics used by the directed checks.
   always @(negedge clk) begin
      if (!rstn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checkOutput("stall_valid_held", 32'(m_valid_a), 32'd1);
            checkOutput("stall_data_stable", 32'(m_data_a), 32'(prev_data));
            checkOutput("stall_last_stable", 32'(m_last_a), 32'(prev_last));
         end
         if (m_valid_a) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            valid_cycles++;
         end
         if (busy_a) busy_cycles++;
         if (done_a) begin
            done_count++;
            done_cyc = cyc;
         end
         if (m_valid_a && m_ready_a) begin
            if (sb_a.size() == 0) begin
               checkOutput("a_unexpected_word", 32'(m_data_a), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb_a.pop_front();
               checkOutput("a_data", 32'(m_data_a), 32'(e.data));
               checkOutput("a_last", 32'(m_last_a), 32'(e.last));
               last_xfer_cyc = cyc;
            end
         end
         prev_stall = m_valid_a && !m_ready_a;
         prev_data  = m_data_a;
         prev_last  = m_last_a;
      end
   end

   // Monitor for instance B (ready always high).
   always @(negedge clk) begin
      if (rstn) begin
         if (done_b) done_count_b++;
         if (m_valid_b && m_ready_b) begin
            if (first_valid_b < 0) first_valid_b = cyc;
            if (sb_b.size() == 0) begin
               checkOutput("b_unexpected_word", 32'(m_data_b), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb_b.pop_front();
               checkOutput("b_data", 32'(m_data_b), 32'(e.data));
               checkOutput("b_last", 32'(m_last_b), 32'(e.last));
               last_xfer_b = cyc;
            end
         end
      end
   end

   task automatic clearStats();
      first_valid_cyc = -1;
      last_xfer_cyc   = -1;
      done_cyc        = -1;
      valid_cycles    = 0;
      busy_cycles     = 0;
      done_count      = 0;
   endtask

   task automatic pushExpected(input int base, input int len);
      for (int i = 0; i < len; i++) begin
         exp_t e;
         e.data = 8'((base + i) % 256);
         e.last = (i == len - 1);
         sb_a.push_back(e);
      end
   endtask

   task automatic pulseStart(input logic [7:0] base, input logic [8:0] len);
      @(posedge clk);
      #1;
      base_a  = base;
      len_a   = len;
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_edge = cyc;
      start_a    = 1'b0;
   endtask

   task automatic waitDone(input string name);
      for (int k = 0; k < 400 && done_count == 0; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      checkOutput(name, 32'(done_count), 32'd1);
   endtask

   task automatic applyStimulus(input logic [7:0] base, input logic [8:0] len,
                                input bit random_ready, input string name);
      rand_ready = random_ready;
      pushExpected(int'(base), int'(len));
      clearStats();
      pulseStart(base, len);
      waitDone({name, "_done_once"});
      checkOutput({name, "_all_words_seen"}, 32'(sb_a.size()), 32'd0);
      rand_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog timeout");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rstn    = 1'b0;
      start_a = 1'b0;
      base_a  = '0;
      len_a   = '0;
      start_b = 1'b0;
      base_b  = '0;
      len_b   = '0;
      m_ready_b = 1'b1;
      first_valid_b = -1;
      last_xfer_b   = -1;
      done_count_b  = 0;
      clearStats();

      // Reset values
      #1;
      checkOutput("rst_busy", 32'(busy_a), 32'd0);
      checkOutput("rst_done", 32'(done_a), 32'd0);
      checkOutput("rst_addr", 32'(rom_addr_a), 32'd0);
      checkOutput("rst_valid", 32'(m_valid_a), 32'd0);
      checkOutput("rst_data", 32'(m_data_a), 32'd0);
      checkOutput("rst_last", 32'(m_last_a), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;

      // Basic burst: latency, back-to-back words, done timing
      applyStimulus(8'h10, 9'd4, 1'b0, "t1");
      checkOutput("t1_first_valid_latency", 32'(first_valid_cyc - start_edge), 32'd2);
      checkOutput("t1_valid_cycles", 32'(valid_cycles), 32'd4);
      checkOutput("t1_span", 32'(last_xfer_cyc - first_valid_cyc), 32'd3);
      checkOutput("t1_done_after_last", 32'(done_cyc - last_xfer_cyc), 32'd1);
      checkOutput("t1_busy_cycles", 32'(busy_cycles), 32'd6);

      // Address wrap at 256
      applyStimulus(8'hFE, 9'd4, 1'b0, "t2");
      checkOutput("t2_span", 32'(last_xfer_cyc - first_valid_cyc), 32'd3);

      // Random backpressure
      applyStimulus(8'h40, 9'd8, 1'b1, "t3");

      // Empty burst
      applyStimulus(8'h55, 9'd0, 1'b0, "t4");
      checkOutput("t4_no_valid", 32'(valid_cycles), 32'd0);
      checkOutput("t4_busy_one_cycle", 32'(busy_cycles), 32'd1);

      // start_i mid-burst is ignored
      pushExpected(8'h80, 8);
      clearStats();
      pulseStart(8'h80, 9'd8);
      repeat (2) @(posedge clk);
      #1;
      base_a  = 8'h00;
      len_a   = 9'd3;
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      waitDone("t5_done_once");
      checkOutput("t5_all_words_seen", 32'(sb_a.size()), 32'd0);
      checkOutput("t5_valid_cycles", 32'(valid_cycles), 32'd8);

      // Reset mid-burst aborts with all outputs low and no done
      pushExpected(8'h20, 8);
      clearStats();
      pulseStart(8'h20, 9'd8);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      checkOutput("t5r_busy", 32'(busy_a), 32'd0);
      checkOutput("t5r_done", 32'(done_a), 32'd0);
      checkOutput("t5r_addr", 32'(rom_addr_a), 32'd0);
      checkOutput("t5r_valid", 32'(m_valid_a), 32'd0);
      checkOutput("t5r_data", 32'(m_data_a), 32'd0);
      checkOutput("t5r_last", 32'(m_last_a), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      sb_a.delete();
      repeat (3) @(posedge clk);
      checkOutput("t5r_no_done", 32'(done_count), 32'd0);
      applyStimulus(8'h30, 9'd5, 1'b0, "t5post");
      checkOutput("t5post_latency", 32'(first_valid_cyc - start_edge), 32'd2);

      // WORD_COUNT=200 full-depth burst wrapping 199 -> 0
      for (int i = 0; i < 200; i++) begin
         exp_t e;
         e.data = 8'((198 + i) % 200);
         e.last = (i == 199);
         sb_b.push_back(e);
      end
      @(posedge clk);
      #1;
      base_b  = 8'd198;
      len_b   = 9'd200;
      start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      for (int k = 0; k < 600 && done_count_b == 0; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      checkOutput("t6_done_once", 32'(done_count_b), 32'd1);
      checkOutput("t6_all_words_seen", 32'(sb_b.size()), 32'd0);
      checkOutput("t6_span", 32'(last_xfer_b - first_valid_b), 32'd199);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
